spell_wb_master: RTL and testbench
==================================

SPELL_WB_MASTER -- requirements
Module: spell_wb_master

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of cycles with o_wb_stb high and no ack before abort (legal range 2..255).
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_we  input  1  1 = write, 0 = read.
REQ-007 cmd_sel  input  4  byte selects.
REQ-008 cmd_addr  input  32  bus address.
REQ-009 cmd_data  input  32  write data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumer ready.
REQ-012 rsp_data  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  transaction aborted by timeout.
REQ-014 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  Wishbone classic initiator controls.
REQ-015 o_wb_sel  output  4; o_wb_addr, o_wb_data  output  32  Wishbone select, address, write data.
REQ-016 i_wb_ack  input  1; i_wb_data  input  32  responder ack and read data.
REQ-017 err_count  output  8  saturating count of timeouts since reset.

Function
REQ-018 The FSM SHALL have states IDLE, BUS, RESP; cmd_ready SHALL equal (state==IDLE).
REQ-019 A command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_we/sel/addr/data SHALL be registered onto o_wb_we/sel/addr/data and o_wb_cyc=o_wb_stb=1 from the next cycle (state BUS).
REQ-020 o_wb_* SHALL be driven only from registers and SHALL hold stable throughout BUS.
REQ-021 In BUS, a rising edge with i_wb_ack=1 SHALL deassert cyc/stb, capture i_wb_data into rsp_data (read) or 0 (write), clear rsp_err, set rsp_valid, and enter RESP.
REQ-022 Minimum latency: accept at cycle N, stb high at N+1, ack at N+1 gives rsp_valid at N+2.
REQ-023 i_wb_ack while not in BUS SHALL be ignored.
REQ-024 A wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack; at count TIMEOUT-1 with no ack, the block SHALL deassert cyc/stb, set rsp_err=1, rsp_data=0, increment err_count (saturating at 255), and enter RESP.
REQ-025 Ack in the same cycle as the timeout limit SHALL win: normal completion, no error.
REQ-026 In RESP, rsp_valid and rsp_data/rsp_err SHALL hold until rsp_valid && rsp_ready, then state SHALL go to IDLE; a new command is accepted no earlier than the following cycle.
REQ-027 Exactly one Wishbone cycle SHALL be outstanding at any time; no pipelined or burst transfers.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE and clear o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data, rsp_valid, rsp_data, rsp_err, err_count and the wait counter; cmd_ready SHALL be 1 after reset.
REQ-029 Reset during BUS SHALL abort the bus cycle with no response generated; a late ack after reset release SHALL be ignored.

Configuration
REQ-030 Macro SPELL_WBM_TIMEOUT_EN: when defined, REQ-024/025 apply; when undefined, the wait counter and timeout abort are removed, BUS waits indefinitely for ack, rsp_err and err_count are tied to 0, and TIMEOUT is unused.

Verification
REQ-031 Write: cmd addr=0x3000_0004, data=0xDEAD_BEEF, sel=0xF, ack 2 cycles after stb -> wb signals match command, rsp_valid with rsp_err=0, rsp_data=0.
REQ-032 Read: addr=0x3000_0000, responder returns 0x1234_5678 with same-cycle ack -> rsp_valid at accept+2, rsp_data=0x1234_5678.
REQ-033 Timeout (macro on, TIMEOUT=16): no ack -> stb high exactly 16 cycles, then rsp_err=1, rsp_data=0, err_count=1; same case with ack on the 16th cycle -> rsp_err=0.
REQ-034 Backpressure: rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0 throughout, spurious ack in RESP ignored.
REQ-035 Reset mid-BUS: reset_n low while stb=1 -> cyc/stb low asynchronously, no rsp_valid, cmd_ready=1 after release.
REQ-036 Macro off: no ack for 1000 cycles -> stb remains high, rsp_valid=0, err_count=0.

Source files
------------

// File: rtl/spell_wb_master_if.sv
// Command/response and Wishbone classic bundle for spell_wb_master.
// master = the bus initiator block, slave = the environment around it.
interface spell_wb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_data,
    input  rsp_ready, i_wb_ack, i_wb_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel,
    output o_wb_addr, o_wb_data
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_data,
    output rsp_ready, i_wb_ack, i_wb_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel,
    input  o_wb_addr, o_wb_data
  );
endinterface

// File: rtl/spell_wb_master.sv
// Single-outstanding Wishbone classic initiator with cmd/rsp handshakes.
// Define SPELL_WBM_TIMEOUT_EN to enable the no-ack timeout abort.
module spell_wb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  spell_wb_master_if.master   bus,
  output logic [7:0]          err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Out-of-range TIMEOUT is rejected at elaboration.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("spell_wb_master: TIMEOUT must be 2..255");
  end

  state_t      state;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdat_q;
  logic        rvld_q;
  logic [31:0] rdat_q;

`ifdef SPELL_WBM_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0]  wait_q;
  logic        rerr_q;
  logic [7:0]  errc_q;

  // Main FSM: accept, run one bus cycle with timeout, hold the response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      addr_q <= '0;
      wdat_q <= '0;
      rvld_q <= 1'b0;
      rdat_q <= '0;
      rerr_q <= 1'b0;
      errc_q <= '0;
      wait_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            we_q   <= bus.cmd_we;
            sel_q  <= bus.cmd_sel;
            addr_q <= bus.cmd_addr;
            wdat_q <= bus.cmd_data;
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            wait_q <= '0;
            state  <= BUS;
          end
        end
        BUS: begin
          if (bus.i_wb_ack) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            rdat_q <= we_q ? 32'd0 : bus.i_wb_data;
            rerr_q <= 1'b0;
            rvld_q <= 1'b1;
            state  <= RESP;
          end else if (wait_q == LIMIT) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            rdat_q <= '0;
            rerr_q <= 1'b1;
            rvld_q <= 1'b1;
            if (errc_q != 8'hFF) begin
              errc_q <= errc_q + 8'd1;
            end
            state  <= RESP;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rvld_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_err = rerr_q;
  assign err_count   = errc_q;
`else
  // Main FSM: accept, run one bus cycle until ack, hold the response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      addr_q <= '0;
      wdat_q <= '0;
      rvld_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            we_q   <= bus.cmd_we;
            sel_q  <= bus.cmd_sel;
            addr_q <= bus.cmd_addr;
            wdat_q <= bus.cmd_data;
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            state  <= BUS;
          end
        end
        BUS: begin
          if (bus.i_wb_ack) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            rdat_q <= we_q ? 32'd0 : bus.i_wb_data;
            rvld_q <= 1'b1;
            state  <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rvld_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_err = 1'b0;
  assign err_count   = 8'd0;
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = rvld_q;
  assign bus.rsp_data  = rdat_q;
  assign bus.o_wb_cyc  = cyc_q;
  assign bus.o_wb_stb  = stb_q;
  assign bus.o_wb_we   = we_q;
  assign bus.o_wb_sel  = sel_q;
  assign bus.o_wb_addr = addr_q;
  assign bus.o_wb_data = wdat_q;

endmodule

// File: tb/tb_spell_wb_master.sv
// Scoreboard bench for spell_wb_master.
// Expected responses are queued at issue and popped at rsp handshake.
module tb_spell_wb_master;
  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  err_count;
  int          n_run = 0;
  int          n_fail = 0;
  rsp_t        sb[$];
  logic        cur_we;
  logic [3:0]  cur_sel;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;

  spell_wb_master_if bus();

  spell_wb_master #(.TIMEOUT(TO)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.master),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    rsp_t e;
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_pop_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] data);
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    cur_we = we; cur_sel = sel; cur_addr = addr; cur_data = data;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_sel   = sel;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'hFFFF_FFFF;
    bus.cmd_data  = 32'hFFFF_FFFF;
    chk("wb_cyc", {31'd0, bus.o_wb_cyc}, 32'd1);
    chk("wb_stb", {31'd0, bus.o_wb_stb}, 32'd1);
    chk("wb_we", {31'd0, bus.o_wb_we}, {31'd0, we});
    chk("wb_sel", {28'd0, bus.o_wb_sel}, {28'd0, sel});
    chk("wb_addr", bus.o_wb_addr, addr);
    chk("wb_data", bus.o_wb_data, data);
    chk("cmd_ready_bus", {31'd0, bus.cmd_ready}, 32'd0);
  endtask

  task automatic respond(input int ack_at, input logic [31:0] rdata,
                         input int max_cyc, output int stb_cyc);
    int   k;
    logic bad;
    k = 0; bad = 1'b0; stb_cyc = 0;
    while (k < max_cyc && bus.o_wb_stb) begin
      stb_cyc++;
      if (bus.o_wb_addr !== cur_addr || bus.o_wb_data !== cur_data ||
          bus.o_wb_sel !== cur_sel || bus.o_wb_we !== cur_we ||
          bus.o_wb_cyc !== 1'b1)
        bad = 1'b1;
      bus.i_wb_ack  = (k == ack_at);
      bus.i_wb_data = (k == ack_at) ? rdata : (32'hBAD0_0000 | k);
      @(posedge clock); #1;
      k++;
    end
    bus.i_wb_ack = 1'b0;
    chk("wb_stable", {31'd0, bad}, 32'd0);
  endtask

  task automatic drain(input int hold);
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("wb_cyc_low", {31'd0, bus.o_wb_cyc}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.i_wb_ack  = (i == 2);
      bus.i_wb_data = 32'hFFFF_0000;
      @(posedge clock); #1;
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_data", bus.rsp_data, sb[0].data);
      chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.i_wb_ack = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
    chk("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic txn(input logic we, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] data,
                     input int ack_at, input logic [31:0] rdata,
                     input int hold, input logic exp_err,
                     input int exp_stb);
    rsp_t e;
    int   n;
    e.err  = exp_err;
    e.data = (we || exp_err) ? 32'd0 : rdata;
    sb.push_back(e);
    issue(we, sel, addr, data);
    respond(ack_at, rdata, 300, n);
    chk("stb_cycles", 32'(n), 32'(exp_stb));
    drain(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   a;
    logic w;
    rsp_t e;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    bus.i_wb_ack  = 1'b0;
    bus.i_wb_data = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
    chk("rst_stb", {31'd0, bus.o_wb_stb}, 32'd0);
    chk("rst_addr", bus.o_wb_addr, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    txn(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 2, 32'h7777_7777,
        0, 1'b0, 3);
    txn(1'b0, 4'hF, 32'h3000_0000, 32'h0, 0, 32'h1234_5678,
        0, 1'b0, 1);
    txn(1'b0, 4'h3, 32'h3000_0008, 32'h0, 1, 32'hA5A5_0F0F,
        5, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      w = 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, 4));
      txn(w, 4'($urandom), $urandom, $urandom, a, $urandom,
          i, 1'b0, a + 1);
    end

`ifdef SPELL_WBM_TIMEOUT_EN
    txn(1'b0, 4'hF, 32'h3000_000C, 32'h0, -1, 32'h0,
        0, 1'b1, TO);
    chk("err_count_1", {24'd0, err_count}, 32'd1);
    txn(1'b0, 4'hF, 32'h3000_000C, 32'h0, TO - 1, 32'h0BAD_F00D,
        0, 1'b0, TO);
    chk("err_count_hold", {24'd0, err_count}, 32'd1);
`else
    issue(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    respond(-1, 32'h0, 1000, n);
    chk("noack_cycles", 32'(n), 32'd1000);
    chk("noack_stb", {31'd0, bus.o_wb_stb}, 32'd1);
    chk("noack_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("noack_err_count", {24'd0, err_count}, 32'd0);
    e.data = 32'hCAFE_F00D;
    e.err  = 1'b0;
    sb.push_back(e);
    respond(0, 32'hCAFE_F00D, 5, n);
    chk("late_ack_cycles", 32'(n), 32'd1);
    drain(0);
`endif

    issue(1'b1, 4'h3, 32'h3000_0020, 32'h55AA_55AA);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("arst_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
    chk("arst_stb", {31'd0, bus.o_wb_stb}, 32'd0);
    chk("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("arst_err_count", {24'd0, err_count}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.i_wb_ack  = 1'b1;
    bus.i_wb_data = 32'h1111_2222;
    @(posedge clock); #1;
    bus.i_wb_ack = 1'b0;
    chk("late_ack_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    chk("late_ack_stb", {31'd0, bus.o_wb_stb}, 32'd0);
    chk("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

    repeat (2) @(posedge clock);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
